// File: rtl/uart_rx_frame_if.sv
// Byte stream from the UART receiver to the core: data with valid/ready, plus
// one-cycle status pulses for framing errors and overruns.
interface uart_rx_frame_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// delivering bytes over a valid/ready handshake with framing-error/overrun pulses.
//
// state   | meaning
// IDLE    | line idle, waiting for a 1->0 edge
// START   | counting to mid start bit; re-check rejects glitches
// DATA    | sampling 8 data bits LSB first
// PARITY  | sampling even-parity bit (UART_RX_PARITY_EN only)
// STOP    | sampling stop bit, delivering or flagging
// BREAK   | line held low after a bad stop; wait for it to go high
module uart_rx_frame #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            uart_rxd_i,
    output logic            busy_o,
    uart_rx_frame_if.master rx_if
);

    localparam int DIV    = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SAMP_W = $clog2(OVERSAMPLE);

    if (DIV < 2) begin : g_div_check
        $error("uart_rx_frame: clock divider DIV=%0d must be >= 2", DIV);
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_os_check
        $error("uart_rx_frame: OVERSAMPLE=%0d must be even and >= 8", OVERSAMPLE);
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_e;

    state_e              state_q;
    logic [1:0]          sync_q;
    logic                rxd_prev_q;
    logic [CNT_W-1:0]    tick_cnt_q;
    logic [CNT_W-1:0]    tick_cnt_d;
    logic [SAMP_W-1:0]   samp_cnt_q;
    logic [2:0]          bit_cnt_q;
    logic [7:0]          shreg_q;
    logic [7:0]          data_q;
    logic                valid_q;
    logic                frame_err_q;
    logic                overrun_q;
    logic                rxd_s;
    logic                tick;
    logic                sample_pt;
    logic                start_edge;
    logic                deliver_ok;

    assign rxd_s      = sync_q[1];
    assign start_edge = rxd_prev_q && !rxd_s;
    assign tick       = (tick_cnt_q == CNT_W'(DIV - 1));
    assign sample_pt  = tick && (samp_cnt_q == '0);

`ifdef UART_RX_PARITY_EN
    logic par_err_q;
    assign deliver_ok = !par_err_q;
`else
    assign deliver_ok = 1'b1;
`endif

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
        if ((state_q == S_IDLE) || (state_q == S_BREAK)) begin
            tick_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q      <= 2'b11;
            rxd_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            samp_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            sync_q      <= {sync_q[0], uart_rxd_i};
            rxd_prev_q  <= rxd_s;
            tick_cnt_q  <= tick_cnt_d;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (valid_q && rx_if.rx_ready) begin
                valid_q <= 1'b0;
            end
            // Sample counter runs down one step per tick; zero marks a sampling point.
            if (tick && (state_q != S_IDLE) && (state_q != S_BREAK)) begin
                samp_cnt_q <= sample_pt ? SAMP_W'(OVERSAMPLE - 1) : samp_cnt_q - SAMP_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        state_q    <= S_START;
                        samp_cnt_q <= SAMP_W'(OVERSAMPLE / 2 - 1);
                        bit_cnt_q  <= '0;
`ifdef UART_RX_PARITY_EN
                        par_err_q  <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    if (sample_pt) begin
                        state_q <= rxd_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (sample_pt) begin
                        shreg_q   <= {rxd_s, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (sample_pt) begin
                        if (^{rxd_s, shreg_q}) begin
                            frame_err_q <= 1'b1;
                            par_err_q   <= 1'b1;
                        end
                        state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (sample_pt) begin
                        if (rxd_s) begin
                            state_q <= S_IDLE;
                            if (deliver_ok) begin
                                // A byte accepted this very cycle frees the holding register.
                                if (!valid_q || rx_if.rx_ready) begin
                                    data_q  <= shreg_q;
                                    valid_q <= 1'b1;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rxd_s) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_valid  = valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;
    assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: serial frames are bit-banged onto the line,
// expected bytes are queued and matched against handshake transfers.
module tb_uart_rx_frame;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115_200;
    localparam int OS       = 16;
    localparam int DIV      = (CLK_FREQ + (BAUD * OS) / 2) / (BAUD * OS);
    localparam int BIT_CYC  = OS * DIV;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int LAT = 2 + (OS / 2 + (9 + PAR_BITS) * OS) * DIV + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxd   = 1'b1;
    logic busy;

    uart_rx_frame_if rx_if ();

    uart_rx_frame #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .uart_rxd_i(rxd),
        .busy_o    (busy),
        .rx_if     (rx_if.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int xfer_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int valid_cyc = 0;
    logic valid_prev = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_if.rx_valid) valid_cyc++;
        if (rx_if.rx_valid && !valid_prev) rise_cyc = cyc;
        valid_prev = rx_if.rx_valid;
        if (rx_if.frame_err) fe_cnt++;
        if (rx_if.overrun) ov_cnt++;
        if (rx_if.rx_valid && rx_if.rx_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0)
                check_eq("sb_underflow", 32'(rx_if.rx_data), 32'hFFFF_FFFF);
            else
                check_eq("rx_data", 32'(rx_if.rx_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        idle(BIT_CYC);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        drive_bit(stop_bit);
        rxd = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, f0, o0, v0;
        rx_if.rx_ready = 1'b1;
        idle(3);
        check_eq("rst_data", 32'(rx_if.rx_data), 32'h00);
        check_eq("rst_valid", 32'(rx_if.rx_valid), 32'h0);
        check_eq("rst_frame_err", 32'(rx_if.frame_err), 32'h0);
        check_eq("rst_overrun", 32'(rx_if.overrun), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        idle(5);

        // single byte, ready held high
        x0 = xfer_cnt; v0 = valid_cyc;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0);
        idle(20);
        check_eq("t1_latency", 32'(rise_cyc - start_cyc), 32'(LAT));
        check_eq("t1_valid_cycles", 32'(valid_cyc - v0), 32'd1);
        check_eq("t1_xfers", 32'(xfer_cnt - x0), 32'd1);
        check_eq("t1_busy", 32'(busy), 32'h0);

        // short low glitch is rejected
        f0 = fe_cnt; v0 = valid_cyc;
        rxd = 1'b0;
        idle(50);
        check_eq("t2_busy_during", 32'(busy), 32'h1);
        idle(50);
        rxd = 1'b1;
        idle(BIT_CYC);
        check_eq("t2_no_valid", 32'(valid_cyc - v0), 32'd0);
        check_eq("t2_no_ferr", 32'(fe_cnt - f0), 32'd0);
        check_eq("t2_busy_after", 32'(busy), 32'h0);

        // bad stop bit, then a good frame
        f0 = fe_cnt; v0 = valid_cyc; x0 = xfer_cnt;
        send_frame(8'hA3, 1'b0, 1'b0);
        idle(BIT_CYC);
        check_eq("t3_ferr_pulses", 32'(fe_cnt - f0), 32'd1);
        check_eq("t3_no_valid", 32'(valid_cyc - v0), 32'd0);
        check_eq("t3_busy", 32'(busy), 32'h0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(20);
        check_eq("t3_xfers", 32'(xfer_cnt - x0), 32'd1);
        check_eq("t3_ferr_total", 32'(fe_cnt - f0), 32'd1);

        // overrun: second byte dropped while first is held
        o0 = ov_cnt; f0 = fe_cnt; x0 = xfer_cnt;
        rx_if.rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(20);
        check_eq("t4_held_data", 32'(rx_if.rx_data), 32'h11);
        check_eq("t4_held_valid", 32'(rx_if.rx_valid), 32'h1);
        check_eq("t4_overrun", 32'(ov_cnt - o0), 32'd1);
        check_eq("t4_no_ferr", 32'(fe_cnt - f0), 32'd0);
        rx_if.rx_ready = 1'b1;
        idle(1);
        check_eq("t4_valid_drop", 32'(rx_if.rx_valid), 32'h0);
        check_eq("t4_xfers", 32'(xfer_cnt - x0), 32'd1);

        // reset in the middle of a frame
        rxd = 1'b0;
        idle(BIT_CYC * 4);
        check_eq("t5_busy_mid", 32'(busy), 32'h1);
        rst_n = 1'b0;
        idle(3);
        check_eq("t5_rst_busy", 32'(busy), 32'h0);
        check_eq("t5_rst_data", 32'(rx_if.rx_data), 32'h00);
        rxd = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(BIT_CYC);
        x0 = xfer_cnt; f0 = fe_cnt; o0 = ov_cnt;
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 1'b0);
        idle(20);
        check_eq("t5_xfers", 32'(xfer_cnt - x0), 32'd1);
        check_eq("t5_no_ferr", 32'(fe_cnt - f0), 32'd0);
        check_eq("t5_no_ovr", 32'(ov_cnt - o0), 32'd0);

`ifdef UART_RX_PARITY_EN
        x0 = xfer_cnt; f0 = fe_cnt; v0 = valid_cyc;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(20);
        check_eq("t6_par_ok_xfer", 32'(xfer_cnt - x0), 32'd1);
        check_eq("t6_par_ok_ferr", 32'(fe_cnt - f0), 32'd0);
        v0 = valid_cyc;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(20);
        check_eq("t6_par_bad_ferr", 32'(fe_cnt - f0), 32'd1);
        check_eq("t6_par_bad_valid", 32'(valid_cyc - v0), 32'd0);
`endif

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
